// File: rtl/tt_vector_runner.sv
`default_nettype none
// ============================================================================
//  Module   : tt_vector_runner
//  Purpose  : On-chip stimulus/response engine. Vectors (stimulus, expected
//             response, compare mask) are loaded serially, replayed into a
//             user DUT one per clock, and each response is checked against
//             its masked expectation a fixed LATENCY edges later. A pass/fail
//             summary (error count, first failing index) is reported.
//  Revision : 1.0 - initial release
// ============================================================================
module tt_vector_runner #(
  parameter int IN_W    = 8,
  parameter int OUT_W   = 8,
  parameter int DEPTH   = 16,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       load_valid,
  output logic                       load_ready,
  input  logic [IN_W-1:0]            load_stim,
  input  logic [OUT_W-1:0]           load_expect,
  input  logic [OUT_W-1:0]           load_mask,
  input  logic                       start,
  input  logic                       stop_on_fail,
  output logic [IN_W-1:0]            dut_in,
  input  logic [OUT_W-1:0]           dut_out,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [CNT_W-1:0]           err_count,
  output logic [$clog2(DEPTH)-1:0]   first_fail,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW:0]      DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]      IDX_ONE = (AW+1)'(1);
  localparam logic [CNT_W-1:0] ERR_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] ERR_MAX = '1;

  // One-hot encoding so busy/done come straight off a state flop.
  localparam logic [2:0] S_IDLE = 3'b001;
  localparam logic [2:0] S_RUN  = 3'b010;
  localparam logic [2:0] S_DONE = 3'b100;

  // --------------------------------------------------------------------------
  // Storage and registers
  // --------------------------------------------------------------------------
  logic [IN_W-1:0]  stim_mem [DEPTH];
  logic [OUT_W-1:0] exp_mem  [DEPTH];
  logic [OUT_W-1:0] mask_mem [DEPTH];

  logic [2:0]                  state_q, state_d;
  logic [AW:0]                 count_q, count_d;
  logic [AW:0]                 idx_q, idx_d;        // next vector to issue
  logic [LATENCY-1:0]          pvld_q, pvld_d;      // in-flight compare valid
  logic [LATENCY-1:0][AW-1:0]  pidx_q, pidx_d;      // in-flight vector index
  logic [IN_W-1:0]             dut_in_q, dut_in_d;
  logic [CNT_W-1:0]            err_q, err_d;
  logic [AW-1:0]               ff_q, ff_d;
  logic                        pass_q, pass_d;
  logic                        sof_q, sof_d;        // stop_on_fail latched at start

  // --------------------------------------------------------------------------
  // Control decode
  // --------------------------------------------------------------------------
  logic          w_idle_like;
  logic          w_clear;
  logic          w_start;
  logic          w_load;
  logic          w_issue;
  logic          w_cmp_vld;
  logic [AW-1:0] w_cmp_idx;
  logic          w_mismatch;
  logic          w_last;
  logic          w_finish;

  // Output/strobe decode from the current state and the request inputs.
  always_comb begin
    w_idle_like = state_q[0] | state_q[2];
    load_ready  = w_idle_like && (count_q < DEPTH_C) && !start && !clear;
    // clear wins over start when both arrive together
    w_clear     = w_idle_like && clear;
    w_start     = w_idle_like && start && !clear;
    w_load      = load_valid && load_ready;
    w_issue     = state_q[1] && (idx_q < count_q);
    w_cmp_vld   = state_q[1] && pvld_q[LATENCY-1];
    w_cmp_idx   = pidx_q[LATENCY-1];
    w_mismatch  = w_cmp_vld &&
                  (|((dut_out ^ exp_mem[w_cmp_idx]) & mask_mem[w_cmp_idx]));
    w_last      = w_cmp_vld && ({1'b0, w_cmp_idx} == (count_q - IDX_ONE));
    w_finish    = w_last || (w_mismatch && sof_q);
  end

  assign busy       = state_q[1];
  assign done       = state_q[2];
  assign pass       = pass_q;
  assign dut_in     = dut_in_q;
  assign err_count  = err_q;
  assign first_fail = ff_q;
  assign count      = count_q;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: an empty store skips RUN and reports an immediate pass.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (w_start) begin
          state_d = (count_q == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_finish) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (w_clear) begin
          state_d = S_IDLE;
        end else if (w_start) begin
          state_d = (count_q == '0) ? S_DONE : S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath next-state: loading, run launch, issue pipeline and scoring.
  // --------------------------------------------------------------------------

  // Compute every datapath register's next value from the decoded strobes.
  always_comb begin
    count_d  = count_q;
    idx_d    = idx_q;
    pvld_d   = pvld_q;
    pidx_d   = pidx_q;
    dut_in_d = dut_in_q;
    err_d    = err_q;
    ff_d     = ff_q;
    pass_d   = pass_q;
    sof_d    = sof_q;

    if (w_clear) begin
      count_d = '0;
      err_d   = '0;
      ff_d    = '0;
      pass_d  = 1'b0;
    end else if (w_start) begin
      err_d  = '0;
      ff_d   = '0;
      sof_d  = stop_on_fail;
      pass_d = (count_q == '0);
      pvld_d = '0;
      if (count_q != '0) begin
        // vector 0 goes out on the start edge itself
        dut_in_d  = stim_mem[0];
        pvld_d[0] = 1'b1;
        pidx_d[0] = '0;
        idx_d     = IDX_ONE;
      end
    end else if (w_load) begin
      count_d = count_q + IDX_ONE;
    end

    if (state_q[1]) begin
      // Age the in-flight compares by one edge.
      for (int s = LATENCY - 1; s > 0; s--) begin
        pvld_d[s] = pvld_q[s-1];
        pidx_d[s] = pidx_q[s-1];
      end
      pvld_d[0] = w_issue;
      pidx_d[0] = idx_q[AW-1:0];

      // Once all vectors are out, dut_in holds the last one while draining.
      if (w_issue) begin
        dut_in_d = stim_mem[idx_q[AW-1:0]];
        idx_d    = idx_q + IDX_ONE;
      end

      if (w_mismatch) begin
        if (err_q != ERR_MAX) begin
          err_d = err_q + ERR_ONE;
        end
        if (err_q == '0) begin
          ff_d = w_cmp_idx;
        end
      end

      // Leaving RUN: park dut_in, drop any remaining compares, post result.
      if (w_finish) begin
        dut_in_d = '0;
        pvld_d   = '0;
        pass_d   = (err_d == '0);
      end
    end
  end

  // Datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      idx_q    <= '0;
      pvld_q   <= '0;
      pidx_q   <= '0;
      dut_in_q <= '0;
      err_q    <= '0;
      ff_q     <= '0;
      pass_q   <= 1'b0;
      sof_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      idx_q    <= idx_d;
      pvld_q   <= pvld_d;
      pidx_q   <= pidx_d;
      dut_in_q <= dut_in_d;
      err_q    <= err_d;
      ff_q     <= ff_d;
      pass_q   <= pass_d;
      sof_q    <= sof_d;
    end
  end

  // Vector store write port; contents are not reset.
  always_ff @(posedge clk) begin
    if (w_load) begin
      stim_mem[count_q[AW-1:0]] <= load_stim;
      exp_mem[count_q[AW-1:0]]  <= load_expect;
      mask_mem[count_q[AW-1:0]] <= load_mask;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tt_vector_runner.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_tt_vector_runner
//  Purpose  : Self-checking bench for tt_vector_runner with a loopback
//             register DUT. A run's expected summary is queued at start and
//             a monitor compares it when done rises.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tt_vector_runner;

  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       rst, clear, load_valid, start, stop_on_fail;
  logic       load_ready;
  logic [7:0] load_stim, load_expect, load_mask;
  logic [7:0] dut_in, dut_out;
  logic       busy, done, pass;
  logic [7:0] err_count;
  logic [3:0] first_fail;
  logic [4:0] count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Loopback register DUT: response equals the stimulus one edge later.
  always @(posedge clk) dut_out <= dut_in;

  tt_vector_runner #(
    .IN_W(8), .OUT_W(8), .DEPTH(16), .LATENCY(LAT), .CNT_W(8)
  ) u_dut (
    .clk(clk), .rst(rst), .clear(clear),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_stim(load_stim), .load_expect(load_expect), .load_mask(load_mask),
    .start(start), .stop_on_fail(stop_on_fail),
    .dut_in(dut_in), .dut_out(dut_out),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail(first_fail), .count(count)
  );

  // Reference vector store as seen by the bench.
  int m_stim [16];
  int m_exp  [16];
  int m_mask [16];
  int m_n = 0;

  typedef struct {
    int n;
    int busy;
    int err;
    int ff;
    int pass;
  } exp_t;

  exp_t sb[$];
  exp_t last_e;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, expv);
    end
  endtask

  // Expected run summary: loopback response == stimulus.
  function automatic exp_t model(input int sof);
    exp_t e;
    e.n    = m_n;
    e.err  = 0;
    e.ff   = 0;
    e.busy = (m_n == 0) ? 0 : m_n - 1 + LAT;
    for (int i = 0; i < m_n; i++) begin
      if (((m_stim[i] ^ m_exp[i]) & m_mask[i]) != 0) begin
        if (e.err == 0) e.ff = i;
        if (e.err < 255) e.err++;
        if (sof != 0) begin
          e.busy = i + LAT;
          break;
        end
      end
    end
    e.pass = (e.err == 0) ? 1 : 0;
    return e;
  endfunction

  // Monitor: checks dut_in each busy cycle and the summary when done rises.
  int   busy_cnt  = 0;
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    int k;
    exp_t e;
    if (rst) begin
      busy_cnt  = 0;
      prev_done = 1'b0;
    end else begin
      if (busy) begin
        if (sb.size() > 0) begin
          k = (busy_cnt < sb[0].n) ? busy_cnt : sb[0].n - 1;
          check("dut_in_run", 32'(dut_in), 32'(m_stim[k]));
        end
        busy_cnt++;
      end
      if (done && !prev_done) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 expected no run pending");
        end else begin
          e = sb.pop_front();
          last_e = e;
          check("busy_cycles", 32'(busy_cnt), 32'(e.busy));
          check("err_count",   32'(err_count), 32'(e.err));
          check("first_fail",  32'(first_fail), 32'(e.ff));
          check("pass",        32'(pass), 32'(e.pass));
          check("dut_in_done", 32'(dut_in), 32'd0);
        end
        busy_cnt = 0;
      end
      prev_done = done;
    end
  end

  task automatic load_vec(input logic [7:0] s, input logic [7:0] e, input logic [7:0] m);
    load_valid  = 1'b1;
    load_stim   = s;
    load_expect = e;
    load_mask   = m;
    @(posedge clk); #1;
    load_valid  = 1'b0;
    if (m_n < 16) begin
      m_stim[m_n] = int'(s);
      m_exp[m_n]  = int'(e);
      m_mask[m_n] = int'(m);
      m_n++;
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    m_n = 0;
  endtask

  task automatic issue_start(input int sof);
    sb.push_back(model(sof));
    start        = 1'b1;
    stop_on_fail = (sof != 0);
    @(posedge clk); #1;
    start        = 1'b0;
    stop_on_fail = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL timeout: pending runs=%0d expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_load_ready"}, 32'(load_ready), 32'd1);
    check({tag, "_dut_in"},     32'(dut_in),     32'd0);
    check({tag, "_busy"},       32'(busy),       32'd0);
    check({tag, "_done"},       32'(done),       32'd0);
    check({tag, "_pass"},       32'(pass),       32'd0);
    check({tag, "_err"},        32'(err_count),  32'd0);
    check({tag, "_ff"},         32'(first_fail), 32'd0);
    check({tag, "_count"},      32'(count),      32'd0);
  endtask

  task automatic load_ramp(input int bad_a, input int bad_b);
    for (int i = 0; i < 16; i++) begin
      if (i == bad_a || i == bad_b) load_vec(8'(i * 17), 8'h00, 8'hFF);
      else                          load_vec(8'(i * 17), 8'(i * 17), 8'hFF);
    end
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; load_valid = 1'b0; start = 1'b0; stop_on_fail = 1'b0;
    load_stim = '0; load_expect = '0; load_mask = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;

    // Clean ramp, then a 17th load against a full store.
    load_ramp(-1, -1);
    check("count_full", 32'(count), 32'd16);
    check("ready_full", 32'(load_ready), 32'd0);
    load_vec(8'hAA, 8'h55, 8'hFF);
    check("count_17th", 32'(count), 32'd16);
    issue_start(0);
    wait_idle();
    check("ramp_done", 32'(done), 32'd1);

    // Two corrupted expectations, counted then stop-on-fail rerun from DONE.
    do_clear();
    check("clear_count", 32'(count), 32'd0);
    check("clear_done",  32'(done),  32'd0);
    load_ramp(5, 9);
    issue_start(0);
    wait_idle();
    issue_start(1);
    wait_idle();

    // Masked-off bits never fail: vector 3 drives 0x00 against 0xF0/0x0F.
    do_clear();
    for (int i = 0; i < 8; i++) begin
      if (i == 3) load_vec(8'h00, 8'hF0, 8'h0F);
      else        load_vec(8'(i + 1), 8'(i + 1), 8'hFF);
    end
    issue_start(0);
    wait_idle();
    // Loading while DONE leaves results intact.
    load_vec(8'h12, 8'h34, 8'hFF);
    check("done_after_load", 32'(done), 32'd1);
    check("err_after_load",  32'(err_count), 32'(last_e.err));
    check("count_after_load", 32'(count), 32'd9);

    // start with load_valid in the same cycle: the load is refused.
    do_clear();
    for (int i = 0; i < 4; i++) load_vec(8'(8'h40 + i), 8'(8'h40 + i), 8'hFF);
    load_valid = 1'b1; load_stim = 8'hEE; load_expect = 8'h00; load_mask = 8'hFF;
    issue_start(0);
    load_valid = 1'b0;
    check("count_start_load", 32'(count), 32'd4);
    wait_idle();

    // Empty store: immediate pass after one edge.
    do_clear();
    issue_start(0);
    check("empty_done", 32'(done), 32'd1);
    check("empty_pass", 32'(pass), 32'd1);
    wait_idle();

    // Reset at edge 4 of a run, then a clean rerun.
    do_clear();
    load_ramp(-1, -1);
    issue_start(0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("midrun_rst");
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    m_n = 0;
    @(posedge clk); #1;
    load_ramp(-1, -1);
    issue_start(0);
    wait_idle();

    // Randomized runs.
    for (int r = 0; r < 8; r++) begin
      int n;
      do_clear();
      n = $urandom_range(1, 16);
      for (int i = 0; i < n; i++) begin
        logic [7:0] s, e, m;
        s = 8'($urandom);
        e = ($urandom_range(0, 2) == 0) ? 8'($urandom) : s;
        case ($urandom_range(0, 3))
          0:       m = 8'h00;
          1:       m = 8'($urandom);
          default: m = 8'hFF;
        endcase
        load_vec(s, e, m);
      end
      issue_start(int'($urandom_range(0, 1)));
      wait_idle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
